fetch_queue: RTL and testbench

- Parametrised successor of the pipelined fetch stage.
- Decouples PC generation from a variable-latency instruction memory:
  - issues requests over a valid/ready port;
  - buffers returned instructions, with their PCs, in a DEPTH-entry FIFO;
  - presents the head entry to decode.
- Handles E-stage redirects (branch or JAL target, JALR ALU result) by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decouples PC generation from a variable-latency instruction memory with a DEPTH-entry {instr, pc} queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            ValidF
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   tag_wr;
  logic [PW-1:0]   tag_rd;

  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] tag_pc  [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] alu_target;
  logic [XLEN-1:0] target;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_keep;
  logic            bypass;
  logic            push;
  logic            fifo_pop;
  logic            head_valid;
  logic [XLEN-1:0] head_instr;
  logic [XLEN-1:0] head_pc;

  always_comb begin
    redirect   = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    alu_target = ALUResultE & ~XLEN'(1);
    target     = (PCSrcE == 2'b10) ? alu_target : PCTargetE;
  end

  // Registered counts only: a pop this cycle frees its slot for requests next cycle.
  assign occupancy      = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = rst && !redirect && (occupancy < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && (count == '0) && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign head_valid = (count != '0) || bypass;
  assign fifo_pop   = (count != '0) && en && !redirect;
  assign push       = rsp_keep && !redirect && !(bypass && en);
  assign head_instr = bypass ? imem_rsp_data : q_instr[rd_ptr];
  assign head_pc    = bypass ? tag_pc[tag_rd] : q_pc[rd_ptr];

  assign ValidF   = head_valid;
  assign InstrF   = head_valid ? head_instr : '0;
  assign PCF      = head_valid ? head_pc : '0;
  assign PCPlus4F = PCF + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Every outstanding request is now stale, minus the one answered this cycle.
        fetch_pc <= target;
        discard  <= inflight - CW'(imem_rsp_valid);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_wr   <= tag_wr + PW'(1);
        end
        if (rsp_keep)
          tag_rd <= tag_rd + PW'(1);
        if (imem_rsp_valid && (discard != '0))
          discard <= discard - CW'(1);
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (fifo_pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(fifo_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      q_instr[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]    <= tag_pc[tag_rd];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized stimulus for fetch_queue against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [1:0]      PCSrcE = 2'b00;
  logic [XLEN-1:0] PCTargetE = '0;
  logic [XLEN-1:0] ALUResultE = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ValidF;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .en(en), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  int          cyc = 0;
  int          last_due = 0;
  int          mem_lat = 1;
  bit          rand_lat = 0;
  int          buffered = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;
  int          n_hs = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    en = 1'b0;
    PCSrcE = 2'b00;
    #1;
    check("rst_valid", ValidF, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_pcf", PCF, 0);
    check("rst_instr", InstrF, 0);
    check("rst_pcplus4", PCPlus4F, 4);
    pend.delete();
    buffered = 0;
    exp_pc = RESET_PC;
    exp_req_pc = RESET_PC;
    last_due = cyc;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model for the coming edge.
  task automatic cycle(input logic en_i, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic rdy);
    logic        redir, rsp, kept, pop, hs, exp_valid;
    logic [31:0] t, p4;
    int          d;
    en = en_i;
    PCSrcE = src;
    PCTargetE = tgt;
    ALUResultE = alu;
    imem_req_ready = rdy;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word(pend[0].addr) : $urandom;
    @(negedge clk);
    redir = (src == 2'b01) || (src == 2'b10);
    t = (src == 2'b10) ? {alu[31:1], 1'b0} : tgt;
    kept = rsp && !pend[0].stale && !redir;
    exp_valid = (buffered != 0);
`ifdef FETCH_BYPASS_EN
    if (buffered == 0 && kept) exp_valid = 1'b1;
`endif
    check("valid", ValidF, exp_valid);
    if (exp_valid) begin
      p4 = exp_pc + 32'd4;
      check("pcf", PCF, exp_pc);
      check("instr", InstrF, word(exp_pc));
      check("pcplus4", PCPlus4F, p4);
    end
    check("req_valid", imem_req_valid, !redir && (pend.size() + buffered < DEPTH));
    hs = imem_req_valid && rdy;
    if (hs) check("req_addr", imem_req_addr, exp_req_pc);

    pop = exp_valid && en_i && !redir;
    if (rsp) void'(pend.pop_front());
    if (redir) begin
      buffered = 0;
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_pc = t;
      exp_req_pc = t;
    end else begin
      buffered = buffered + int'(kept) - int'(pop);
      if (pop) exp_pc = exp_pc + 32'd4;
    end
    if (hs) begin
      d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: imem_req_addr, due: d, stale: redir});
      if (!redir) exp_req_pc = exp_req_pc + 32'd4;
      n_hs++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input logic en_i);
    repeat (n) cycle(en_i, 2'b00, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    #2;
    // Sequential stream, 1-cycle memory.
    mem_lat = 1;
    do_reset(2);
    run(20, 1'b1);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    do_reset(2);
    n_hs = 0;
    run(10, 1'b0);
    check("hold_reqs", n_hs, DEPTH);
    run(12, 1'b1);

    // Three in flight on a 3-cycle memory, then redirect to 0x100.
    mem_lat = 3;
    do_reset(2);
    run(3, 1'b1);
    cycle(1'b1, 2'b01, 32'h0000_0100, 32'h0, 1'b1);
    run(14, 1'b1);

    // JALR target with bit 0 cleared, then back-to-back redirects.
    cycle(1'b1, 2'b10, 32'h0, 32'h0000_0203, 1'b1);
    run(8, 1'b1);
    cycle(1'b1, 2'b01, 32'h0000_0040, 32'h0, 1'b1);
    cycle(1'b1, 2'b01, 32'h0000_0080, 32'h0, 1'b1);
    run(14, 1'b1);

    // Fill the queue, then stream with simultaneous push and pop.
    mem_lat = 1;
    run(6, 1'b0);
    run(8, 1'b1);
    run(4, 1'b0);

    // Reset mid-stream with 2 in flight and 2 buffered.
    mem_lat = 2;
    do_reset(2);
    run(4, 1'b0);
    do_reset(2);
    run(10, 1'b1);

    // Randomized traffic.
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [1:0]  src;
      r = int'($urandom_range(0, 19));
      src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 499) == 0) do_reset(1);
      cycle($urandom_range(0, 3) != 0, src, $urandom, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
